// File: rtl/sdram_cmd_queue.sv
// rtl/sdram_cmd_queue.sv - host-to-SDRAM command FIFO with single-outstanding issue FSM
// Optional per-type issue counters when SDRAM_CMD_QUEUE_STATS_EN is defined.
module sdram_cmd_queue #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 23
) (
    input  logic                  clk,
    input  logic                  reset_n_port,
    input  logic                  host_req_valid_port,
    output logic                  host_req_ready_port,
    input  logic                  host_req_we_port,
    input  logic [ADDR_WIDTH-1:0] host_req_addr_port,
    input  logic [31:0]           host_req_wdata_port,
    input  logic [3:0]            host_req_mask_port,
    output logic                  host_rsp_valid_port,
    output logic [31:0]           host_rsp_rdata_port,
    output logic [ADDR_WIDTH-1:0] soc_side_addr_port,
    output logic [31:0]           soc_side_wr_data_port,
    output logic [3:0]            soc_side_wr_mask_port,
    output logic                  soc_side_wr_en_port,
    output logic                  soc_side_rd_en_port,
    input  logic                  soc_side_busy_port,
    input  logic                  soc_side_ready_port,
    input  logic [31:0]           soc_side_rd_data_port
`ifdef SDRAM_CMD_QUEUE_STATS_EN
    ,
    output logic [15:0]           stat_rd_count_port,
    output logic [15:0]           stat_wr_count_port
`endif
);

    localparam int IDX_W   = $clog2(DEPTH);
    localparam int PTR_W   = IDX_W + 1;
    localparam int ENTRY_W = 1 + ADDR_WIDTH + 32 + 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t state, state_next;

    logic [ENTRY_W-1:0]    fifo_mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  load_issue;
    logic                  done;
    logic                  cur_is_read;

    logic [ENTRY_W-1:0]    head;
    logic                  head_we;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [31:0]           head_wdata;
    logic [3:0]            head_mask;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                   (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);

    assign host_req_ready_port = ~full;
    assign push = host_req_valid_port & ~full;

    assign head = fifo_mem[rd_ptr[IDX_W-1:0]];
    assign {head_we, head_addr, head_wdata, head_mask} = head;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[IDX_W-1:0]] <= {host_req_we_port, host_req_addr_port,
                                            host_req_wdata_port, host_req_mask_port};
        end
    end

    always_ff @(posedge clk or negedge reset_n_port) begin
        if (!reset_n_port) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n_port) begin
        if (!reset_n_port) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!empty && !soc_side_busy_port) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // A ready seen before busy rises means the controller finished quickly.
                if (soc_side_ready_port) begin
                    state_next = IDLE;
                end else if (soc_side_busy_port) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (soc_side_ready_port) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        load_issue = 1'b0;
        pop        = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE:      load_issue = ~empty & ~soc_side_busy_port;
            ISSUE:     pop        = 1'b1;
            WAIT_BUSY: done       = soc_side_ready_port;
            WAIT_DONE: done       = soc_side_ready_port;
            default:   load_issue = 1'b0;
        endcase
    end

    // Command fields are captured on entry to ISSUE and held until the next one.
    always_ff @(posedge clk or negedge reset_n_port) begin
        if (!reset_n_port) begin
            soc_side_addr_port    <= '0;
            soc_side_wr_data_port <= '0;
            soc_side_wr_mask_port <= '0;
            soc_side_wr_en_port   <= 1'b0;
            soc_side_rd_en_port   <= 1'b0;
            cur_is_read           <= 1'b0;
        end else begin
            soc_side_wr_en_port <= load_issue & head_we;
            soc_side_rd_en_port <= load_issue & ~head_we;
            if (load_issue) begin
                soc_side_addr_port    <= head_addr;
                soc_side_wr_data_port <= head_wdata;
                soc_side_wr_mask_port <= head_mask;
                cur_is_read           <= ~head_we;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n_port) begin
        if (!reset_n_port) begin
            host_rsp_valid_port <= 1'b0;
            host_rsp_rdata_port <= '0;
        end else begin
            host_rsp_valid_port <= done & cur_is_read;
            if (done && cur_is_read) begin
                host_rsp_rdata_port <= soc_side_rd_data_port;
            end
        end
    end

`ifdef SDRAM_CMD_QUEUE_STATS_EN
    always_ff @(posedge clk or negedge reset_n_port) begin
        if (!reset_n_port) begin
            stat_rd_count_port <= '0;
            stat_wr_count_port <= '0;
        end else if (state == ISSUE) begin
            if (soc_side_rd_en_port && stat_rd_count_port != 16'hFFFF) begin
                stat_rd_count_port <= stat_rd_count_port + 16'd1;
            end
            if (soc_side_wr_en_port && stat_wr_count_port != 16'hFFFF) begin
                stat_wr_count_port <= stat_wr_count_port + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sdram_cmd_queue.sv
// tb/tb_sdram_cmd_queue.sv - self-checking bench for sdram_cmd_queue
module tb_sdram_cmd_queue;

    logic        clk;
    logic        reset_n_port;
    logic        host_req_valid_port;
    logic        host_req_ready_port;
    logic        host_req_we_port;
    logic [22:0] host_req_addr_port;
    logic [31:0] host_req_wdata_port;
    logic [3:0]  host_req_mask_port;
    logic        host_rsp_valid_port;
    logic [31:0] host_rsp_rdata_port;
    logic [22:0] soc_side_addr_port;
    logic [31:0] soc_side_wr_data_port;
    logic [3:0]  soc_side_wr_mask_port;
    logic        soc_side_wr_en_port;
    logic        soc_side_rd_en_port;
    logic        soc_side_busy_port;
    logic        soc_side_ready_port;
    logic [31:0] soc_side_rd_data_port;

    sdram_cmd_queue #(.DEPTH(4), .ADDR_WIDTH(23)) dut (
        .clk                   (clk),
        .reset_n_port          (reset_n_port),
        .host_req_valid_port   (host_req_valid_port),
        .host_req_ready_port   (host_req_ready_port),
        .host_req_we_port      (host_req_we_port),
        .host_req_addr_port    (host_req_addr_port),
        .host_req_wdata_port   (host_req_wdata_port),
        .host_req_mask_port    (host_req_mask_port),
        .host_rsp_valid_port   (host_rsp_valid_port),
        .host_rsp_rdata_port   (host_rsp_rdata_port),
        .soc_side_addr_port    (soc_side_addr_port),
        .soc_side_wr_data_port (soc_side_wr_data_port),
        .soc_side_wr_mask_port (soc_side_wr_mask_port),
        .soc_side_wr_en_port   (soc_side_wr_en_port),
        .soc_side_rd_en_port   (soc_side_rd_en_port),
        .soc_side_busy_port    (soc_side_busy_port),
        .soc_side_ready_port   (soc_side_ready_port),
        .soc_side_rd_data_port (soc_side_rd_data_port)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        valid;
        logic        we;
        logic [22:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic        busy;
        logic        ready;
        logic [31:0] rd_data;
        logic        e_ready;
        logic        e_wr_en;
        logic        e_rd_en;
        logic [22:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_mask;
        logic        e_rsp_valid;
        logic [31:0] e_rdata;
    } vec_t;

    typedef struct {
        logic        we;
        logic [22:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } req_t;

    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam int NVEC = 30;

    int checks = 0;
    int errors = 0;
    vec_t vecs [NVEC];
    req_t issue_q [$];
    logic [31:0] rsp_q [$];
    logic [31:0] mem_model [16];

    function automatic vec_t mk(int v, int we, int a, logic [31:0] d, int m, int b, int r,
                                logic [31:0] rd, int er, int ew, int erd, int ea,
                                logic [31:0] ed, int em, int ev, logic [31:0] erdata);
        vec_t t;
        t.valid = v[0];       t.we = we[0];        t.addr = a[22:0];
        t.wdata = d;          t.mask = m[3:0];     t.busy = b[0];
        t.ready = r[0];       t.rd_data = rd;      t.e_ready = er[0];
        t.e_wr_en = ew[0];    t.e_rd_en = erd[0];  t.e_addr = ea[22:0];
        t.e_wdata = ed;       t.e_mask = em[3:0];  t.e_rsp_valid = ev[0];
        t.e_rdata = erdata;
        return t;
    endfunction

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem_model[i] = 32'h0;
        reset_n_port = 1'b0;
        host_req_valid_port = 1'b0;
        host_req_we_port = 1'b0;
        host_req_addr_port = '0;
        host_req_wdata_port = '0;
        host_req_mask_port = '0;
        soc_side_busy_port = 1'b0;
        soc_side_ready_port = 1'b0;
        soc_side_rd_data_port = '0;

        // single write, read with busy latency, full-FIFO backpressure, then setup for reset
        vecs[0]  = mk(1,1,'h10,DB,'hF,0,0,0, 1,0,0,0,0,0,0,0);
        vecs[1]  = mk(0,0,0,0,0,0,0,0, 1,0,0,0,0,0,0,0);
        vecs[2]  = mk(0,0,0,0,0,0,0,0, 1,1,0,'h10,DB,'hF,0,0);
        vecs[3]  = mk(0,0,0,0,0,1,0,0, 1,0,0,'h10,DB,'hF,0,0);
        vecs[4]  = mk(0,0,0,0,0,0,1,0, 1,0,0,'h10,DB,'hF,0,0);
        vecs[5]  = mk(0,0,0,0,0,0,0,0, 1,0,0,'h10,DB,'hF,0,0);
        vecs[6]  = mk(1,0,'h10,0,0,0,0,0, 1,0,0,'h10,DB,'hF,0,0);
        vecs[7]  = mk(0,0,0,0,0,0,0,0, 1,0,0,'h10,DB,'hF,0,0);
        vecs[8]  = mk(0,0,0,0,0,0,0,0, 1,0,1,'h10,0,0,0,0);
        vecs[9]  = mk(0,0,0,0,0,1,0,0, 1,0,0,'h10,0,0,0,0);
        vecs[10] = mk(0,0,0,0,0,1,0,0, 1,0,0,'h10,0,0,0,0);
        vecs[11] = mk(0,0,0,0,0,0,1,DB, 1,0,0,'h10,0,0,0,0);
        vecs[12] = mk(0,0,0,0,0,0,0,0, 1,0,0,'h10,0,0,1,DB);
        vecs[13] = mk(0,0,0,0,0,0,0,0, 1,0,0,'h10,0,0,0,DB);
        vecs[14] = mk(1,1,1,1,1,1,0,0, 1,0,0,'h10,0,0,0,DB);
        vecs[15] = mk(1,1,2,2,2,1,0,0, 1,0,0,'h10,0,0,0,DB);
        vecs[16] = mk(1,1,3,3,3,1,0,0, 1,0,0,'h10,0,0,0,DB);
        vecs[17] = mk(1,1,4,4,4,1,0,0, 1,0,0,'h10,0,0,0,DB);
        vecs[18] = mk(1,1,5,5,5,1,0,0, 0,0,0,'h10,0,0,0,DB);
        vecs[19] = mk(1,1,5,5,5,0,0,0, 0,0,0,'h10,0,0,0,DB);
        vecs[20] = mk(1,1,5,5,5,0,0,0, 0,1,0,1,1,1,0,DB);
        vecs[21] = mk(1,1,5,5,5,0,0,0, 1,0,0,1,1,1,0,DB);
        vecs[22] = mk(0,0,0,0,0,0,1,0, 0,0,0,1,1,1,0,DB);
        vecs[23] = mk(0,0,0,0,0,0,0,0, 0,0,0,1,1,1,0,DB);
        vecs[24] = mk(0,0,0,0,0,0,0,0, 0,1,0,2,2,2,0,DB);
        vecs[25] = mk(0,0,0,0,0,0,1,0, 1,0,0,2,2,2,0,DB);
        vecs[26] = mk(0,0,0,0,0,0,0,0, 1,0,0,2,2,2,0,DB);
        vecs[27] = mk(1,1,6,6,6,0,0,0, 1,1,0,3,3,3,0,DB);
        vecs[28] = mk(0,0,0,0,0,1,0,0, 1,0,0,3,3,3,0,DB);
        vecs[29] = mk(0,0,0,0,0,1,0,0, 1,0,0,3,3,3,0,DB);

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs",
              128'({soc_side_wr_en_port, soc_side_rd_en_port, soc_side_addr_port,
                    soc_side_wr_data_port, soc_side_wr_mask_port, host_rsp_valid_port,
                    host_rsp_rdata_port}), 128'(0));
        reset_n_port = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            host_req_valid_port   = vecs[i].valid;
            host_req_we_port      = vecs[i].we;
            host_req_addr_port    = vecs[i].addr;
            host_req_wdata_port   = vecs[i].wdata;
            host_req_mask_port    = vecs[i].mask;
            soc_side_busy_port    = vecs[i].busy;
            soc_side_ready_port   = vecs[i].ready;
            soc_side_rd_data_port = vecs[i].rd_data;
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  128'({host_req_ready_port, soc_side_wr_en_port, soc_side_rd_en_port,
                        soc_side_addr_port, soc_side_wr_data_port, soc_side_wr_mask_port,
                        host_rsp_valid_port, host_rsp_rdata_port}),
                  128'({vecs[i].e_ready, vecs[i].e_wr_en, vecs[i].e_rd_en, vecs[i].e_addr,
                        vecs[i].e_wdata, vecs[i].e_mask, vecs[i].e_rsp_valid, vecs[i].e_rdata}));
            @(posedge clk);
            #1;
        end

        // reset while WAIT_DONE with three entries queued
        #2 reset_n_port = 1'b0;
        #1;
        check("async_reset_outputs",
              128'({soc_side_wr_en_port, soc_side_rd_en_port, soc_side_addr_port,
                    soc_side_wr_data_port, soc_side_wr_mask_port, host_rsp_valid_port,
                    host_rsp_rdata_port}), 128'(0));
        soc_side_busy_port = 1'b0;
        soc_side_ready_port = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_n_port = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("post_reset%0d", i),
                  128'({host_req_ready_port, soc_side_wr_en_port, soc_side_rd_en_port,
                        host_rsp_valid_port}), 128'(4'b1000));
            soc_side_ready_port = 1'b0;
        end

        // alternating writes/reads with random controller latency
        @(posedge clk);
        #1;
        fork
            begin : pusher
                int  cyc;
                logic acc;
                req_t r;
                for (int i = 0; i < 10; i++) begin
                    r.we    = (i % 2 == 0);
                    r.addr  = 23'h100 + 23'(i >> 1);
                    r.wdata = r.we ? (32'hA5000000 + 32'(i)) : 32'h0;
                    r.mask  = 4'(i + 1);
                    host_req_valid_port = 1'b1;
                    host_req_we_port    = r.we;
                    host_req_addr_port  = r.addr;
                    host_req_wdata_port = r.wdata;
                    host_req_mask_port  = r.mask;
                    cyc = 0;
                    acc = 1'b0;
                    while (!acc && cyc < 500) begin
                        @(negedge clk);
                        acc = host_req_ready_port;
                        if (acc) begin
                            issue_q.push_back(r);
                            if (!r.we) rsp_q.push_back(32'hA5000000 + 32'(i - 1));
                        end
                        @(posedge clk);
                        #1;
                        cyc++;
                    end
                    if (!acc) fail("push_timeout");
                end
                host_req_valid_port = 1'b0;
            end
            begin : controller
                int   done_cnt;
                int   idle_cyc;
                int   lat;
                logic was_rd;
                logic [3:0] idx;
                req_t e;
                done_cnt = 0;
                idle_cyc = 0;
                while (done_cnt < 10 && idle_cyc < 2000) begin
                    @(posedge clk);
                    #1;
                    if (soc_side_wr_en_port && soc_side_rd_en_port) begin
                        check("en_exclusive", 128'(2'b11), 128'(2'b01));
                    end
                    if (soc_side_wr_en_port || soc_side_rd_en_port) begin
                        if (issue_q.size() == 0) begin
                            fail("issue_unexpected");
                        end else begin
                            e = issue_q.pop_front();
                            check($sformatf("issue%0d", done_cnt),
                                  128'({soc_side_wr_en_port, soc_side_rd_en_port, soc_side_addr_port,
                                        soc_side_wr_data_port, soc_side_wr_mask_port}),
                                  128'({e.we, ~e.we, e.addr, e.wdata, e.mask}));
                        end
                        was_rd = soc_side_rd_en_port;
                        idx = soc_side_addr_port[3:0];
                        if (soc_side_wr_en_port) mem_model[idx] = soc_side_wr_data_port;
                        lat = int'($urandom_range(3, 0));
                        @(posedge clk);
                        #1;
                        repeat (lat) begin
                            soc_side_busy_port = 1'b1;
                            @(posedge clk);
                            #1;
                        end
                        soc_side_busy_port = 1'b0;
                        soc_side_ready_port = 1'b1;
                        soc_side_rd_data_port = was_rd ? mem_model[idx] : 32'hBAD0BAD0;
                        @(posedge clk);
                        #1;
                        soc_side_ready_port = 1'b0;
                        soc_side_rd_data_port = 32'h0;
                        done_cnt++;
                    end else begin
                        idle_cyc++;
                    end
                end
                if (done_cnt < 10) fail("issue_timeout");
            end
            begin : responder
                int got;
                int cyc;
                logic [31:0] exp_d;
                got = 0;
                cyc = 0;
                while (got < 5 && cyc < 3000) begin
                    @(negedge clk);
                    cyc++;
                    if (host_rsp_valid_port) begin
                        exp_d = (rsp_q.size() != 0) ? rsp_q.pop_front() : 32'hFFFFFFFF;
                        check($sformatf("rsp%0d", got), 128'(host_rsp_rdata_port), 128'(exp_d));
                        got++;
                    end
                end
                if (got < 5) fail("rsp_timeout");
            end
        join

        repeat (4) begin
            @(negedge clk);
            check("no_extra_rsp", 128'(host_rsp_valid_port), 128'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_cmd_queue.md
SDRAM_CMD_QUEUE -- requirements
Module: sdram_cmd_queue

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, FIFO entries (power of 2, at least 2).
REQ-002 SHALL provide parameter ADDR_WIDTH, default 23, word address width (8M x 32-bit).
REQ-003 SHALL provide port clk  input  1  single clock for all logic.
REQ-004 SHALL provide port reset_n_port  input  1  asynchronous active-low reset.
REQ-005 SHALL provide port host_req_valid_port  input  1  host request present.
REQ-006 SHALL provide port host_req_ready_port  output  1  queue accepts request this cycle.
REQ-007 SHALL provide port host_req_we_port  input  1  1 = write, 0 = read.
REQ-008 SHALL provide port host_req_addr_port  input  ADDR_WIDTH  word address.
REQ-009 SHALL provide port host_req_wdata_port  input  32  write data.
REQ-010 SHALL provide port host_req_mask_port  input  4  byte mask, passed unchanged.
REQ-011 SHALL provide port host_rsp_valid_port  output  1  one-cycle read-data strobe.
REQ-012 SHALL provide port host_rsp_rdata_port  output  32  read data.
REQ-013 SHALL provide ports soc_side_addr_port (ADDR_WIDTH), soc_side_wr_data_port (32), soc_side_wr_mask_port (4), soc_side_wr_en_port (1), soc_side_rd_en_port (1) as outputs to the controller.
REQ-014 SHALL provide ports soc_side_busy_port (1), soc_side_ready_port (1), soc_side_rd_data_port (32) as inputs from the controller.

Function
REQ-015 SHALL store accepted requests in a DEPTH-entry FIFO; push when host_req_valid_port and host_req_ready_port are both 1.
REQ-016 SHALL drive host_req_ready_port = not full; a pop in the same cycle SHALL NOT make a full FIFO ready.
REQ-017 SHALL use read/write pointers of log2(DEPTH)+1 bits; wrap-around modulo 2*DEPTH; full = MSBs differ and the lower bits are equal.
REQ-018 SHALL implement states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-019 IDLE -> ISSUE when the FIFO is non-empty and soc_side_busy_port = 0; otherwise remain in IDLE.
REQ-020 ISSUE SHALL last exactly one cycle: drive the head entry on soc_side_addr/wr_data/wr_mask, pulse soc_side_wr_en_port (write) or soc_side_rd_en_port (read), pop the FIFO, go to WAIT_BUSY.
REQ-021 SHALL hold soc_side_addr/wr_data/wr_mask registered and stable from ISSUE until the next ISSUE.
REQ-022 WAIT_BUSY -> WAIT_DONE when soc_side_busy_port = 1; a soc_side_ready_port pulse seen in WAIT_BUSY SHALL be treated as completion (-> IDLE).
REQ-023 WAIT_DONE -> IDLE on a soc_side_ready_port pulse.
REQ-024 On completion of a read, SHALL register soc_side_rd_data_port into host_rsp_rdata_port and pulse host_rsp_valid_port one cycle later (1-cycle latency from ready).
REQ-025 Write completion SHALL produce no host response.
REQ-026 SHALL keep at most one request outstanding at the controller; responses return in request order.
REQ-027 soc_side_wr_en_port and soc_side_rd_en_port SHALL never be 1 in the same cycle.

Reset
REQ-028 On reset_n_port = 0, SHALL immediately clear pointers (empty), state = IDLE, all soc_side_* outputs = 0, host_rsp_valid_port = 0, host_rsp_rdata_port = 0; host_req_ready_port = 1 after release.
REQ-029 Reset mid-operation SHALL discard queued and in-flight requests without generating a response.

Configuration
REQ-030 With macro SDRAM_CMD_QUEUE_STATS_EN defined, SHALL add outputs stat_rd_count_port and stat_wr_count_port (16 bits each) counting ISSUE cycles per type, saturating at 16'hFFFF, reset to 0.
REQ-031 Without SDRAM_CMD_QUEUE_STATS_EN, these ports and counters SHALL NOT exist; all other behaviour identical.

Verification
REQ-032 Single write addr 23'h000010, data 32'hDEADBEEF, mask 4'hF, busy low -> one-cycle wr_en pulse with those values in ISSUE; no host_rsp_valid.
REQ-033 Read addr 23'h000010; model raises busy 2 cycles, then ready with rd_data 32'hDEADBEEF -> host_rsp_valid one cycle later with rdata 32'hDEADBEEF.
REQ-034 Push 5 requests back-to-back with busy held high, DEPTH=4 -> host_req_ready low after the 4th push; 5th accepted only after the first ISSUE.
REQ-035 Push 10 alternating reads/writes with random controller latency -> issue order and read responses match push order; pointers wrap with no loss.
REQ-036 Assert reset_n_port during WAIT_DONE with 3 entries queued -> all outputs 0 asynchronously; after release, FIFO empty, no stale issue or response.
